// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit shared definitions: HI/LO-class funct codes,
// FSM state and operation-kind enums, funct classifiers.
package muldiv_unit_pkg;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_e;

    typedef enum logic {
        OP_MUL,
        OP_DIV
    } op_e;

    function automatic logic is_hilo(input logic [5:0] f);
        return f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                         F_MULT, F_MULTU, F_DIV, F_DIVU};
    endfunction

    // MULT/MULTU/DIV/DIVU occupy 0x18..0x1b
    function automatic logic is_long(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration on the {acc, q} pair.
// Ports: op_i kind, acc_i/q_i current pair, m_i multiplicand/divisor,
// acc_o/q_o next pair.
module muldiv_step
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_e              op_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem;
    logic [WIDTH:0] diff;

    always_comb begin
        sum   = {1'b0, acc_i} + {1'b0, m_i};
        rem   = {acc_i, q_i[WIDTH-1]};
        diff  = rem - {1'b0, m_i};
        acc_o = acc_i;
        q_o   = q_i;
        unique case (op_i)
            OP_MUL: begin
                // multiplier bits leave q from the bottom while
                // product bits shift in from acc
                if (q_i[0]) {acc_o, q_o} = {sum, q_i[WIDTH-1:1]};
                else        {acc_o, q_o} = {1'b0, acc_i, q_i[WIDTH-1:1]};
            end
            OP_DIV: begin
                if (!diff[WIDTH]) begin
                    acc_o = diff[WIDTH-1:0];
                    q_o   = {q_i[WIDTH-2:0], 1'b1};
                end else begin
                    acc_o = rem[WIDTH-1:0];
                    q_o   = {q_i[WIDTH-2:0], 1'b0};
                end
            end
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS multiply/divide with HI/LO registers.
// Ports: clk, reset_n, op_valid/funct/rs_val/rt_val/cancel in;
// stall, busy, mf_data, hi, lo out.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_valid,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             cancel,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] mf_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] qr_q, qr_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] rs_q, rs_d;
    op_e              op_q, op_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;

    logic             hilo;
    logic             accept;
    logic             sgn;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] step_acc, step_q;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rmd;

    assign hilo   = is_hilo(funct);
    assign accept = op_valid & hilo & (state_q == S_IDLE) & ~cancel;

    // MULT and DIV are the even codes of the long group
    assign sgn   = ~funct[0];
    assign a_neg = sgn & rs_val[WIDTH-1];
    assign b_neg = sgn & rt_val[WIDTH-1];
    assign a_mag = a_neg ? -rs_val : rs_val;
    assign b_mag = b_neg ? -rt_val : rt_val;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op_i  (op_q),
        .acc_i (acc_q),
        .q_i   (qr_q),
        .m_i   (m_q),
        .acc_o (step_acc),
        .q_o   (step_q)
    );

    assign prod = neg_q ? -{acc_q, qr_q} : {acc_q, qr_q};
    assign quo  = neg_q ? -qr_q : qr_q;
    assign rmd  = rneg_q ? -acc_q : acc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept && is_long(funct)) state_d = S_RUN;
            S_RUN: begin
                if (cancel)                state_d = S_IDLE;
                else if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = state_q != S_IDLE;
        stall   = op_valid & hilo & busy;
        mf_data = '0;
        if (accept && funct == F_MFHI) mf_data = hi_q;
        if (accept && funct == F_MFLO) mf_data = lo_q;
    end

    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        acc_d  = acc_q;
        qr_d   = qr_q;
        m_d    = m_q;
        rs_d   = rs_q;
        op_d   = op_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        dz_d   = dz_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept && funct == F_MTHI) hi_d = rs_val;
                if (accept && funct == F_MTLO) lo_d = rs_val;
                if (accept && is_long(funct)) begin
                    cnt_d  = '0;
                    acc_d  = '0;
                    op_d   = funct[1] ? OP_DIV : OP_MUL;
                    qr_d   = funct[1] ? a_mag : b_mag;
                    m_d    = funct[1] ? b_mag : a_mag;
                    rs_d   = rs_val;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    dz_d   = funct[1] & (rt_val == '0);
                end
            end
            S_RUN: begin
                acc_d = step_acc;
                qr_d  = step_q;
                cnt_d = (cancel || cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            end
            S_FIX: begin
                if (!cancel) begin
                    if (op_q == OP_MUL) begin
                        {hi_d, lo_d} = prod;
                    end else if (dz_q) begin
                        hi_d = rs_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rmd;
                        lo_d = quo;
                    end
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            acc_q  <= '0;
            qr_q   <= '0;
            m_q    <= '0;
            rs_q   <= '0;
            op_q   <= OP_MUL;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            acc_q  <= acc_d;
            qr_q   <= qr_d;
            m_q    <= m_d;
            rs_q   <= rs_d;
            op_q   <= op_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
            dz_q   <= dz_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit.
// Expected HI/LO are queued at issue and checked at completion.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         reset_n;
    logic         op_valid;
    logic [5:0]   funct;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         cancel;
    logic         stall;
    logic         busy;
    logic [W-1:0] mf_data;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [63:0] sb[$];

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .op_valid (op_valid),
        .funct    (funct),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .cancel   (cancel),
        .stall    (stall),
        .busy     (busy),
        .mf_data  (mf_data),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference: {HI, LO}
    function automatic logic [63:0] model(
        input logic [5:0] f,
        input logic [31:0] a,
        input logic [31:0] b
    );
        longint sa, sb_, sq, sr;
        logic [63:0] ua, ub, r;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        r = '0;
        case (f)
            F_MULT:  r = 64'(sa * sb_);
            F_MULTU: r = ua * ub;
            F_DIV: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb_;
                    sr = sa % sb_;
                    r = {sr[31:0], sq[31:0]};
                end
            end
            F_DIVU: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else r = {(ua % ub) , 32'h0} | (ua / ub);
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            pass_cnt++;
    endtask

    // present at cycle 0, accepted at edge 0; returns at cycle 1 start
    task automatic issue(input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input bit track);
        op_valid = 1'b1;
        funct = f;
        rs_val = a;
        rt_val = b;
        if (track) sb.push_back(model(f, a, b));
        @(posedge clk); #1;
        op_valid = 1'b0;
        funct = 6'h00;
    endtask

    task automatic wait_result(input string nm);
        int n;
        logic [63:0] e;
        n = 0;
        @(negedge clk);
        chk({nm, "_busy1"}, 32'(busy), 32'd1);
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, n, W + 1);
        total_cnt++;
        if (sb.size() == 0) begin
            $display("FAIL %s_sb: got empty queue expected entry", nm);
        end else begin
            pass_cnt++;
            e = sb.pop_front();
            chk({nm, "_hi"}, hi, e[63:32]);
            chk({nm, "_lo"}, lo, e[31:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        op_valid = 1'b1;
        funct = F_MFHI;
        rs_val = 32'h5555_aaaa;
        rt_val = 32'h1;
        cancel = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_mf", mf_data, 0);
        op_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_multu();
        issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        wait_result("multu_max");
    endtask

    task automatic test_signed();
        issue(F_MULT, -32'sd3, 32'd7, 1);
        wait_result("mult_neg");
        issue(F_DIV, -32'sd7, 32'd2, 1);
        wait_result("div_neg");
        issue(F_MULT, 32'h8000_0000, 32'h8000_0000, 1);
        wait_result("mult_min");
        issue(F_DIV, 32'd100, -32'sd9, 1);
        wait_result("div_negdiv");
    endtask

    task automatic test_div_edge();
        issue(F_DIVU, 32'd7, 32'd0, 1);
        wait_result("divu_zero");
        issue(F_DIV, -32'sd5, 32'd0, 1);
        wait_result("div_zero");
        issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        wait_result("div_ovf");
        issue(F_DIVU, 32'hFFFF_FFFF, 32'd16, 1);
        wait_result("divu_big");
    endtask

    task automatic test_stalled_read();
        bit ok;
        logic [63:0] e;
        issue(F_DIV, 32'd100, 32'd7, 1);
        op_valid = 1'b1;
        funct = F_MFLO;
        ok = 1;
        for (int c = 1; c <= W + 1; c++) begin
            @(negedge clk);
            if (stall !== 1'b1) ok = 0;
        end
        chk("mflo_stall_held", 32'(ok), 1);
        @(negedge clk);
        chk("mflo_release", 32'(stall), 0);
        chk("mflo_data", mf_data, 14);
        e = sb.pop_front();
        chk("div100_hi", hi, e[63:32]);
        @(posedge clk); #1;
        funct = F_MFHI;
        @(negedge clk);
        chk("mfhi_data", mf_data, 2);
        @(posedge clk); #1;
        op_valid = 1'b0;
        funct = 6'h00;
    endtask

    task automatic test_cancel();
        issue(F_MTLO, 32'h0, 32'h0, 0);
        issue(F_MTHI, 32'h1234, 32'h0, 0);
        op_valid = 1'b1;
        funct = F_MFHI;
        @(negedge clk);
        chk("mt_mf_hi", mf_data, 32'h1234);
        @(posedge clk); #1;
        op_valid = 1'b0;
        issue(F_MULT, 32'd55, 32'd66, 0);
        for (int c = 1; c < 5; c++) begin
            @(posedge clk); #1;
        end
        op_valid = 1'b1;
        funct = 6'h20;
        @(negedge clk);
        chk("nonhilo_nostall", 32'(stall), 0);
        for (int c = 5; c < 10; c++) begin
            @(posedge clk); #1;
        end
        op_valid = 1'b0;
        funct = 6'h00;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        @(negedge clk);
        chk("cancel_busy", 32'(busy), 0);
        repeat (40) @(posedge clk);
        #1;
        chk("cancel_hi", hi, 32'h1234);
        chk("cancel_lo", lo, 0);
    endtask

    task automatic test_reset_mid();
        issue(F_DIVU, 32'd1000, 32'd3, 0);
        for (int c = 1; c < 20; c++) begin
            @(posedge clk); #1;
        end
        #1;
        reset_n = 1'b0;
        #1;
        chk("rmid_busy", 32'(busy), 0);
        chk("rmid_hi", hi, 0);
        chk("rmid_lo", lo, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        issue(F_MULTU, 32'd3, 32'd5, 1);
        wait_result("post_rst_mul");
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [63:0] e;
        issue(F_MULT, 32'h0001_2345, -32'sd77, 1);
        op_valid = 1'b1;
        funct = F_MULTU;
        rs_val = 32'hDEAD_BEEF;
        rt_val = 32'h0BAD_F00D;
        sb.push_back(model(F_MULTU, rs_val, rt_val));
        ok = 1;
        for (int c = 1; c <= W + 1; c++) begin
            @(negedge clk);
            if (stall !== 1'b1) ok = 0;
        end
        chk("b2b_stall_held", 32'(ok), 1);
        @(negedge clk);
        chk("b2b_release", 32'(stall), 0);
        e = sb.pop_front();
        chk("b2b_first_hi", hi, e[63:32]);
        chk("b2b_first_lo", lo, e[31:0]);
        @(posedge clk); #1;
        op_valid = 1'b0;
        funct = 6'h00;
        wait_result("b2b_second");
    endtask

    initial begin
        op_valid = 1'b0;
        funct = 6'h00;
        rs_val = '0;
        rt_val = '0;
        cancel = 1'b0;
        test_reset();
        test_multu();
        test_signed();
        test_div_edge();
        test_stalled_read();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide sequencer with architectural HI/LO registers for the pipelined MIPS core. Sits beside the EX-stage ALU. Accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from ID/EX, runs a shift-add multiply or restoring divide over WIDTH cycles, and raises a stall request whenever an HI/LO-class instruction arrives while an operation is in flight.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- clk  in  1  core clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  EX holds an R-type instruction this cycle.
- funct  in  6  R-type funct field; only the eight HI/LO-class codes are acted on, all others are ignored.
- rs_val  in  WIDTH  forwarded rs operand (dividend / multiplicand / MT source).
- rt_val  in  WIDTH  forwarded rt operand (divisor / multiplier).
- cancel  in  1  flush of the issuing instruction; abort the in-flight operation.
- stall  out  1  hold IF/ID/EX; combinational.
- busy  out  1  operation in flight (state ≠ IDLE).
- mf_data  out  WIDTH  HI for MFHI, LO for MFLO; otherwise 0.
- hi, lo  out  WIDTH  current architectural HI and LO.

## Operation
- FSM states:
  - IDLE: accepts work.
  - RUN: iteration counter runs 0..WIDTH-1.
  - FIX: one cycle of sign fixup and HI/LO write.
- Accept condition: op_valid, a HI/LO-class funct, state IDLE, and cancel=0.
  - MTHI/MTLO: write rs_val into HI/LO at that edge.
  - MFHI/MFLO: drive mf_data combinationally in the same cycle.
  - MULT/MULTU/DIV/DIVU: latch operands, operation kind and signedness, then go to RUN.
- stall = op_valid & HI/LO-class funct & (state ≠ IDLE). A non-HI/LO funct never stalls.
- Signed operations (MULT, DIV):
  - Operands are converted to magnitudes before iterating.
  - Product is negated when the operand signs differ.
  - Quotient is negated when the operand signs differ; the remainder takes the dividend's sign.
- Multiply result: HI = upper WIDTH bits of the 2·WIDTH-bit product, LO = lower WIDTH bits.
- Divide result: LO = quotient, HI = remainder.
- Divide by zero, signed or unsigned: HI = rs_val, LO = all ones. Sign fixup is skipped. Latency is unchanged.
- Signed overflow 0x80000000 / -1: LO = 0x80000000, HI = 0.
- In RUN, each cycle performs one shift-add step (multiply) or one shift-subtract-restore step (divide). After the WIDTH-1 step, go to FIX.
- FIX: apply sign fixup, write HI and LO, return to IDLE.
- cancel while in RUN or FIX: return to IDLE at the next edge. HI/LO are unchanged; the FIX write is suppressed.
- cancel in IDLE: the concurrent op is not accepted.

## Timing
- Reset (async assert): state IDLE, counter 0, HI = LO = 0, busy = 0. stall and mf_data then follow IDLE rules.
- MT*: takes effect at the accept edge. A following MF* one cycle later reads the new value.
- MULT/DIV accepted at edge 0:
  - busy is high from cycle 1 through cycle WIDTH+1 (RUN, then FIX).
  - HI/LO are written at the end of cycle WIDTH+1.
  - The new values are visible from cycle WIDTH+2 (cycle 34 at default WIDTH).
- A stalled MF* releases in the first IDLE cycle and returns the new value in that same cycle.
- A back-to-back MULT behind a busy MULT stalls, then is accepted in the first IDLE cycle.
- reset_n asserted mid-operation: immediate IDLE with HI/LO cleared. No partial result is written.

## Structure
- Shared package holds:
  - funct constants MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1a, DIVU 0x1b;
  - the FSM state enum (IDLE, RUN, FIX);
  - the op-kind enum (MUL, DIV).
- One sub-module, muldiv_step: a combinational single-iteration datapath (shift-add or shift-subtract-restore) on the {acc, q} register pair. The FSM, counter, sign handling and HI/LO registers stay in muldiv_unit.

## Test plan
- MULTU with rs = rt = 0xFFFFFFFF:
  - busy high for cycles 1–33;
  - from cycle 34, HI = 0xFFFFFFFE, LO = 0x00000001.
- Signed operations:
  - MULT -3 × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB;
  - DIV -7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- Division edge cases:
  - DIVU 7 / 0 → HI = 7, LO = 0xFFFFFFFF;
  - DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Stalled read: DIV 100 / 7, then MFLO in cycle 1.
  - stall is high in cycles 1–33;
  - in cycle 34, stall = 0 and mf_data = 14;
  - MFHI in the next cycle returns 2.
- Cancel: MTHI 0x1234, then MULT, then cancel in cycle 10.
  - busy = 0 from cycle 11;
  - HI stays 0x1234 and LO stays 0.
- Reset mid-operation: reset_n low during cycle 20 of a DIVU.
  - busy, HI and LO read 0 immediately;
  - after release, a new MULTU 3 × 5 gives LO = 15, HI = 0.
